// File: rtl/iter_div_unit.sv
// iter_div_unit: iterative restoring integer divider for the EX stage
// (DIV.W / DIV.WU / MOD.W / MOD.WU).
//
// Operands are reduced to unsigned magnitudes on accept. They are divided
// BITS_PER_CYCLE quotient bits per cycle, MSB first. The signs are restored
// in a single FIX cycle. Results are then presented with a one-cycle done pulse.
//
// Parameters
//   WIDTH          operand/result width (>= 4)
//   BITS_PER_CYCLE quotient bits retired per CALC cycle (1, 2 or 4, divides WIDTH)
//
// Ports
//   clk            clock
//   rst            synchronous reset, active-low
//   flush          pipeline flush, cancels any operation in flight
//   start          request, sampled only in IDLE
//   signed_op      1 = two's-complement divide, 0 = unsigned
//   dividend       numerator, sampled with an accepted start
//   divisor        denominator, sampled with an accepted start
//   busy           high from the cycle after accept through the done cycle
//   done           one-cycle pulse, results valid
//   quotient       quotient, held until the next result
//   remainder      remainder, held until the next result
//   divide_by_zero divisor was zero, held like the results
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, an operation whose dividend magnitude is below its divisor
//   magnitude skips CALC entirely. When undefined, every operation takes N+2 cycles.
module iter_div_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divide_by_zero
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_N_C   = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  // Two's-complement negation. The negation of MIN is MIN, which is
  // exactly the magnitude 2^(WIDTH-1) read as unsigned.
  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    return (~v) + ONE_C;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH:0]   rem_r;      // partial remainder, one guard bit
  logic [WIDTH-1:0] quo_r;      // dividend shifts out as quotient shifts in
  logic [WIDTH-1:0] dsr_r;      // divisor magnitude
  logic             signed_r;
  logic             sign_q_r;
  logic             sign_r_r;
  logic             dbz_r;

  logic [WIDTH-1:0] abs_dvd_s;
  logic [WIDTH-1:0] abs_dsr_s;
  logic [WIDTH:0]   step_rem_s;
  logic [WIDTH-1:0] step_quo_s;
  logic [WIDTH-1:0] fix_q_s;
  logic [WIDTH-1:0] fix_r_s;

  // Operand magnitudes; reinterpretation only for signed operations.
  always_comb begin
    if (signed_op && dividend[WIDTH-1]) begin
      abs_dvd_s = neg_f(dividend);
    end else begin
      abs_dvd_s = dividend;
    end
    if (signed_op && divisor[WIDTH-1]) begin
      abs_dsr_s = neg_f(divisor);
    end else begin
      abs_dsr_s = divisor;
    end
  end

`ifdef DIV_EARLY_OUT_EN
  logic early_s;

  // Early-out when the quotient is known to be zero.
  always_comb begin
    early_s = (divisor != ZERO_C) && (abs_dvd_s < abs_dsr_s);
  end
`endif

  // BITS_PER_CYCLE restoring shift-subtract steps, MSB first.
  // A zero divisor always subtracts, so the quotient saturates to all ones
  // and the remainder ends up equal to the dividend magnitude.
  always_comb begin
    step_rem_s = rem_r;
    step_quo_s = quo_r;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      step_rem_s = {step_rem_s[WIDTH-1:0], step_quo_s[WIDTH-1]};
      step_quo_s = {step_quo_s[WIDTH-2:0], 1'b0};
      if (step_rem_s >= {1'b0, dsr_r}) begin
        step_rem_s    = step_rem_s - {1'b0, dsr_r};
        step_quo_s[0] = 1'b1;
      end else begin
        step_quo_s[0] = 1'b0;
      end
    end
  end

  // Sign fix-up. For a zero divisor the quotient stays all ones. Negating
  // the remainder magnitude restores the original dividend bits.
  always_comb begin
    if (signed_r && sign_q_r && !dbz_r) begin
      fix_q_s = neg_f(quo_r);
    end else begin
      fix_q_s = quo_r;
    end
    if (signed_r && sign_r_r) begin
      fix_r_s = neg_f(rem_r[WIDTH-1:0]);
    end else begin
      fix_r_s = rem_r[WIDTH-1:0];
    end
  end

  // Control FSM and all datapath/output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= S_IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      rem_r          <= {(WIDTH+1){1'b0}};
      quo_r          <= ZERO_C;
      dsr_r          <= ZERO_C;
      signed_r       <= 1'b0;
      sign_q_r       <= 1'b0;
      sign_r_r       <= 1'b0;
      dbz_r          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      quotient       <= ZERO_C;
      remainder      <= ZERO_C;
      divide_by_zero <= 1'b0;
    end else if (flush) begin
      state_r <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            dsr_r    <= abs_dsr_s;
            signed_r <= signed_op;
            sign_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_r <= dividend[WIDTH-1];
            dbz_r    <= (divisor == ZERO_C);
            cnt_r    <= CNT_N_C;
`ifdef DIV_EARLY_OUT_EN
            if (early_s) begin
              rem_r   <= {1'b0, abs_dvd_s};
              quo_r   <= ZERO_C;
              state_r <= S_FIX;
            end else begin
              rem_r   <= {(WIDTH+1){1'b0}};
              quo_r   <= abs_dvd_s;
              state_r <= S_CALC;
            end
`else
            rem_r   <= {(WIDTH+1){1'b0}};
            quo_r   <= abs_dvd_s;
            state_r <= S_CALC;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        S_CALC: begin
          rem_r <= step_rem_s;
          quo_r <= step_quo_s;
          cnt_r <= cnt_r - CNT_ONE_C;
          if (cnt_r == CNT_ONE_C) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_FIX: begin
          quotient       <= fix_q_s;
          remainder      <= fix_r_s;
          divide_by_zero <= dbz_r;
          done           <= 1'b1;
          state_r        <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
